// File: rtl/div_clk_prog.sv
// Runtime-programmable clock divider with shadowed divide/high-time values.
// Optional DIV_TICK_EN macro enables the rise_tick/fall_tick strobes.
module div_clk_prog #(
    parameter int CNT_W    = 16,
    parameter int DEF_DIV  = 120,
    parameter int DEF_HIGH = 60
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] div_val,
    input  logic [CNT_W-1:0] high_val,
    output logic             clk_out,
    output logic             rise_tick,
    output logic             fall_tick,
    output logic             pending
);

    localparam logic [CNT_W-1:0] DEF_D = CNT_W'(DEF_DIV);
    localparam logic [CNT_W-1:0] DEF_H = CNT_W'(DEF_HIGH);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO   = CNT_W'(2);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_act;
    logic [CNT_W-1:0] high_act;
    logic [CNT_W-1:0] div_sh;
    logic [CNT_W-1:0] high_sh;

    logic [CNT_W-1:0] div_clamp;
    logic [CNT_W-1:0] high_clamp;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] div_nxt;
    logic [CNT_W-1:0] high_nxt;
    logic             wrap;
    logic             apply;
    logic             pend_nxt;

    // Clamp requested values so the output always has both phases
    always_comb begin
        div_clamp  = div_val;
        high_clamp = high_val;
        if (div_val < TWO) begin
            div_clamp = TWO;
        end
        if (high_val == '0) begin
            high_clamp = ONE;
        end else if (high_val >= div_clamp) begin
            high_clamp = div_clamp - ONE;
        end
    end

    // Next counter / active values; shadow applies at wrap or when parked
    always_comb begin
        wrap     = (cnt == div_act - ONE);
        apply    = pending && (wrap || !en);
        div_nxt  = apply ? div_sh : div_act;
        high_nxt = apply ? high_sh : high_act;
        pend_nxt = load || (pending && !apply);
        if (en) begin
            cnt_nxt = wrap ? '0 : cnt + ONE;
        end else begin
            cnt_nxt = div_nxt - ONE;
        end
    end

    // State registers; clk_out is derived from next values to align with cnt
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= DEF_D - ONE;
            div_act  <= DEF_D;
            high_act <= DEF_H;
            div_sh   <= DEF_D;
            high_sh  <= DEF_H;
            pending  <= 1'b0;
            clk_out  <= 1'b0;
        end else begin
            cnt      <= cnt_nxt;
            div_act  <= div_nxt;
            high_act <= high_nxt;
            pending  <= pend_nxt;
            clk_out  <= en && (cnt_nxt < high_nxt);
            if (load) begin
                div_sh  <= div_clamp;
                high_sh <= high_clamp;
            end
        end
    end

`ifdef DIV_TICK_EN
    // Period-edge strobes, registered alongside clk_out
    always_ff @(posedge clk) begin
        if (rst) begin
            rise_tick <= 1'b0;
            fall_tick <= 1'b0;
        end else begin
            rise_tick <= en && (cnt_nxt == '0);
            fall_tick <= en && (cnt_nxt == high_nxt);
        end
    end
`else
    assign rise_tick = 1'b0;
    assign fall_tick = 1'b0;
`endif

endmodule

// File: doc/div_clk_prog.md
Name: div_clk_prog

Overview:
- Runtime-programmable clock divider, successor to the fixed 12 MHz → 100 kHz divider.
- Generates a divided square wave with a programmable period and high time from the system clock.
- New divide values load safely at period boundaries, so the output never produces a runt pulse.
- Feeds slow-protocol blocks (sensor bit-bangers, display scanners); the tick outputs are intended as clock enables rather than as a real clock.

Parameters:
CNT_W, 16, width of counter and divide/high-time values
DEF_DIV, 120, period in clk cycles after reset (12 MHz/120 = 100 kHz)
DEF_HIGH, 60, high time in clk cycles after reset

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
en  input  1  run enable; 0 parks the divider
load  input  1  one-cycle strobe: capture div_val/high_val
div_val  input  CNT_W  requested period in clk cycles
high_val  input  CNT_W  requested high time in clk cycles
clk_out  output  1  registered divided square wave
rise_tick  output  1  one-cycle strobe on the first high cycle of each period
fall_tick  output  1  one-cycle strobe on the first low cycle of each period
pending  output  1  captured values not yet applied

Behaviour:
- Registers:
  - cnt (CNT_W bits).
  - Active pair div_act/high_act.
  - Shadow pair div_sh/high_sh.
  - pending.
  - clk_out, rise_tick, fall_tick: all flops, no combinational outputs.
- Reset (rst=1 at a clk edge, overrides everything):
  - div_act=div_sh=DEF_DIV; high_act=high_sh=DEF_HIGH.
  - cnt=DEF_DIV-1; clk_out=0, ticks=0, pending=0.
- Clamping is applied at capture:
  - div<2 → 2.
  - high=0 → 1.
  - high≥div → div-1.
  - Result: 1 ≤ high_act ≤ div_act-1, so the output always toggles.
- load=1: shadow ← clamped inputs, pending ← 1. A second load while pending overwrites the shadow (last wins).
- Running (en=1):
  - If cnt==div_act-1 (wrap), next cnt=0; otherwise cnt+1.
  - On a wrap with pending=1 (pending as registered before this edge), active ← shadow and pending ← 0.
  - A load in the wrap cycle itself does not apply at that wrap. It sets pending and applies at the following wrap.
- Output relation: in every cycle with cnt=k and en=1, clk_out = (k < high_act), where high_act is the value in force for that period.
  - clk_out is computed from next-cnt and next-active values so it is aligned with cnt.
  - Period = div_act cycles; high time = high_act cycles.
- Ticks (while en=1):
  - rise_tick=1 exactly in cycles with cnt==0.
  - fall_tick=1 exactly in cycles with cnt==high_act.
- Parked (en=0):
  - Pending values apply immediately (next edge); pending ← 0.
  - cnt ← (applied div)-1; clk_out, ticks ← 0.
  - On en rising, the first enabled cycle has cnt=0, clk_out=1, rise_tick=1. There is no partial first period.
- en dropping mid-period: next cycle is parked, clk_out=0 immediately. A truncated high phase is allowed only on en deassertion.
- rst mid-period: immediate return to reset state. Restart follows the en rules.

Optional Feature:
DIV_TICK_EN
- Defined: rise_tick/fall_tick are generated as specified.
- Undefined: both ports are driven constant 0 and the tick logic is not synthesised. clk_out and pending are unchanged.

Test Plan:
1. Reset, en=1, defaults → clk_out period 120 cycles, high 60 cycles starting at cnt=0; rise_tick every 120 cycles, fall_tick 60 cycles after each rise_tick; pending=0.
2. Mid-period (cnt=30) load div=10/high=3 → pending=1 until the wrap after cnt=119; then period 10, high 3, pending=0 on the first new cycle; the old period completes intact.
3. load in the wrap cycle with div=8/high=4 → the next period is still 120/60; the period after it is 8/4.
4. load div=1/high=0 then div=5/high=9 in consecutive cycles → last wins, clamped to period 5, high 4.
5. en=0 with load div=4/high=2, then en=1 → first enabled cycle clk_out=1 with rise_tick=1; pattern 1,1,0,0 repeating.
6. rst asserted at cnt=70 with clk_out=0 → next cycle cnt=119, clk_out=0, active 120/60; with en=1 the next cycle is cnt=0, clk_out=1.
